// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with debounce for the lock.
// Drives col strobe, senses row, emits one key_valid pulse per accepted press.
// Ports: clk, rst (async high), row[3:0] in, col[3:0] out (one-hot low),
//        key_code[3:0] last accepted key, key_valid pulse, key_held level.
`timescale 1ns/1ps
module keypad_scanner #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_SCANS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DEBOUNCE,
    S_HELD,
    S_RELEASE
  } state_t;

  logic [DW-1:0] r_div;
  logic [1:0]    r_c;
  logic [3:0]    r_row_s1;
  logic [3:0]    r_row_s2;
  logic [1:0]    r_hits;
  logic [3:0]    r_hit_code;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;

  logic          w_slot_end;
  logic          w_scan_end;
  logic [3:0]    w_low;
  logic [2:0]    w_slot_n;
  logic [2:0]    w_sum;
  logic [1:0]    w_hits_next;
  logic [1:0]    w_slot_row;
  logic [3:0]    w_code_next;
  logic          w_none;
  logic          w_one;

  function automatic logic [3:0] f_map(input logic [1:0] r,
                                       input logic [1:0] c);
    logic [3:0] v;
    case ({r, c})
      4'h0: v = 4'h1;
      4'h1: v = 4'h2;
      4'h2: v = 4'h3;
      4'h3: v = 4'hA;
      4'h4: v = 4'h4;
      4'h5: v = 4'h5;
      4'h6: v = 4'h6;
      4'h7: v = 4'hB;
      4'h8: v = 4'h7;
      4'h9: v = 4'h8;
      4'hA: v = 4'h9;
      4'hB: v = 4'hC;
      4'hC: v = 4'hE;
      4'hD: v = 4'h0;
      4'hE: v = 4'hF;
      default: v = 4'hD;
    endcase
    return v;
  endfunction

  assign col        = ~(4'b0001 << r_c);
  assign w_slot_end = (r_div == DIV_MAX);
  assign w_scan_end = w_slot_end && (r_c == 2'd3);
  assign w_low      = ~r_row_s2;

  assign w_slot_n = 3'(w_low[0]) + 3'(w_low[1])
                  + 3'(w_low[2]) + 3'(w_low[3]);
  assign w_sum    = {1'b0, r_hits} + w_slot_n;
  // Closed-switch tally saturates at 2: anything beyond is just MULTI.
  assign w_hits_next = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];

  // Several rows can be low at once; the index only matters when one is.
  always_comb begin
    w_slot_row = 2'd0;
    priority case (1'b1)
      w_low[0]: w_slot_row = 2'd0;
      w_low[1]: w_slot_row = 2'd1;
      w_low[2]: w_slot_row = 2'd2;
      w_low[3]: w_slot_row = 2'd3;
      default:  w_slot_row = 2'd0;
    endcase
  end

  assign w_code_next = (w_slot_n == 3'd1) ? f_map(w_slot_row, r_c)
                                          : r_hit_code;
  assign w_none = (w_hits_next == 2'd0);
  assign w_one  = (w_hits_next == 2'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_c      <= 2'd0;
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
    end else begin
      r_row_s1 <= row;
      r_row_s2 <= r_row_s1;
      if (w_slot_end) begin
        r_div <= '0;
        r_c   <= r_c + 2'd1;
      end else begin
        r_div <= r_div + DW'(1);
      end
    end
  end

  // Per-scan accumulation; cleared at scan end so each scan stands alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hits     <= 2'd0;
      r_hit_code <= 4'h0;
    end else if (w_slot_end) begin
      if (r_c == 2'd3) begin
        r_hits     <= 2'd0;
        r_hit_code <= 4'h0;
      end else begin
        r_hits     <= w_hits_next;
        r_hit_code <= w_code_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_cand    <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (w_scan_end) begin
        unique case (r_state)
          S_IDLE: begin
            if (w_one) begin
              r_cand <= w_code_next;
              if (DEBOUNCE_SCANS == 1) begin
                key_code  <= w_code_next;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                r_cnt     <= '0;
                r_state   <= S_HELD;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_DEBOUNCE;
              end
            end
          end
          S_DEBOUNCE: begin
            if (w_one) begin
              if (w_code_next == r_cand) begin
                if (r_cnt >= CNT_LAST) begin
                  key_code  <= w_code_next;
                  key_valid <= 1'b1;
                  key_held  <= 1'b1;
                  r_cnt     <= '0;
                  r_state   <= S_HELD;
                end else begin
                  r_cnt <= r_cnt + CW'(1);
                end
              end else begin
                r_cand <= w_code_next;
                r_cnt  <= CW'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_IDLE;
            end
          end
          S_HELD: begin
            if (w_none) begin
              if (DEBOUNCE_SCANS == 1) begin
                key_held <= 1'b0;
                r_cnt    <= '0;
                r_state  <= S_IDLE;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= S_RELEASE;
              end
            end
          end
          S_RELEASE: begin
            if (w_none) begin
              if (r_cnt >= CNT_LAST) begin
                key_held <= 1'b0;
                r_cnt    <= '0;
                r_state  <= S_IDLE;
              end else begin
                r_cnt <= r_cnt + CW'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= S_HELD;
            end
          end
          default: begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of strobe, debounce and key events.
// Keypad model pulls a row low while its column is strobed for pressed keys.
`timescale 1ns/1ps
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DS = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] keys = '0;

  int         cyc = 0;
  int         pulses = 0;
  int         pulse_cyc = 0;
  int         dbl = 0;
  logic [3:0] pulse_code = 4'h0;
  logic       prev_valid = 1'b0;

  int tests = 0;
  int fails = 0;

  keypad_scanner #(
    .SCAN_DIV(SD),
    .DEBOUNCE_SCANS(DS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .row(row),
    .col(col),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    prev_valid <= key_valid;
    if (key_valid) begin
      pulses     <= pulses + 1;
      pulse_cyc  <= cyc;
      pulse_code <= key_code;
      if (prev_valid) dbl <= dbl + 1;
    end
  end

  typedef struct {
    logic [15:0] keys;
    logic [3:0]  code;
    int          extra_scans;
  } vec_t;

  vec_t vt[8];

  function automatic logic [15:0] kb(input int i);
    kb = 16'h0001 << i;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act,
                         input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that starts a new scan (col back to 1110).
  task automatic align();
    logic [3:0] p;
    p = col;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (col == 4'b1110 && p == 4'b0111) return;
      p = col;
    end
    chk("align_timeout", 0, 1);
  endtask

  task automatic wait_pulse(input string nm, input int base,
                            input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (pulses != base) return;
    end
    chk({nm, "_timeout"}, pulses - base, 1);
  endtask

  task automatic wait_held(input string nm, input logic v,
                           input int budget, output int t);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (key_held == v) begin
        t = cyc;
        return;
      end
    end
    chk({nm, "_timeout"}, int'(key_held), int'(v));
    t = cyc;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t0;
    int t;
    int drop;
    logic [3:0] e;

    vt[0] = '{kb(5),  4'h5, 20};
    vt[1] = '{kb(0),  4'h1, 2};
    vt[2] = '{kb(3),  4'hA, 2};
    vt[3] = '{kb(10), 4'h9, 2};
    vt[4] = '{kb(12), 4'hE, 2};
    vt[5] = '{kb(13), 4'h0, 2};
    vt[6] = '{kb(11), 4'hC, 2};
    vt[7] = '{kb(4),  4'h4, 2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_col", int'(col), 14);
    chk("rst_code", int'(key_code), 0);
    chk("rst_valid", int'(key_valid), 0);
    chk("rst_held", int'(key_held), 0);

    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 64; k++) begin
      e = ~(4'b0001 << ((k / SD) % 4));
      chk("strobe", int'(col), int'(e));
      tick();
    end

    for (int i = 0; i < 8; i++) begin
      base = pulses;
      align();
      keys = vt[i].keys;
      t0 = cyc;
      wait_pulse("press", base, 200);
      chk("press_code", int'(pulse_code), int'(vt[i].code));
      chk_rng("press_lat", pulse_cyc - t0, 96, 135);
      chk("press_held", int'(key_held), 1);
      repeat (vt[i].extra_scans * 32) tick();
      chk("no_repeat", pulses - base, 1);
      align();
      keys = '0;
      t0 = cyc;
      wait_held("release", 1'b0, 200, t);
      chk_rng("release_lat", t - t0, 96, 131);
      chk("release_nopulse", pulses - base, 1);
    end

    base = pulses;
    align();
    t0 = cyc;
    for (int k = 0; k < 96; k++) begin
      keys = (((k / 20) % 2) == 0) ? kb(14) : 16'h0;
      tick();
    end
    keys = kb(14);
    chk("bounce_quiet", pulses - base, 0);
    wait_pulse("bounce", base, 200);
    chk("bounce_code", int'(pulse_code), 15);
    chk("bounce_held", int'(key_held), 1);
    repeat (64) tick();
    chk("bounce_once", pulses - base, 1);

    align();
    keys = '0;
    drop = 0;
    for (int k = 0; k < 128; k++) begin
      if (k == 64) keys = kb(14);
      tick();
      if (!key_held) drop = 1;
    end
    chk("short_rel_held", drop, 0);
    chk("short_rel_nopulse", pulses - base, 1);
    align();
    keys = '0;
    repeat (128) tick();
    chk("long_rel_held", int'(key_held), 0);
    base = pulses;
    align();
    keys = kb(13);
    wait_pulse("zero", base, 200);
    chk("zero_code", int'(pulse_code), 0);
    align();
    keys = '0;
    wait_held("zero_rel", 1'b0, 200, t);

    base = pulses;
    align();
    keys = kb(0) | kb(1);
    repeat (160) tick();
    chk("multi_quiet", pulses - base, 0);
    chk("multi_held", int'(key_held), 0);
    keys = kb(0);
    t0 = cyc;
    wait_pulse("multi", base, 200);
    chk("multi_code", int'(pulse_code), 1);
    chk_rng("multi_lat", pulse_cyc - t0, 96, 131);
    align();
    keys = '0;
    wait_held("multi_rel", 1'b0, 200, t);

    base = pulses;
    align();
    keys = kb(15);
    repeat (48) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_col", int'(col), 14);
    chk("mid_rst_code", int'(key_code), 0);
    chk("mid_rst_valid", int'(key_valid), 0);
    chk("mid_rst_held", int'(key_held), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    t0 = cyc;
    chk("mid_rst_nopulse", pulses - base, 0);
    wait_pulse("after_rst", base, 200);
    chk("after_rst_code", int'(pulse_code), 13);
    chk_rng("after_rst_lat", pulse_cyc - t0, 96, 131);
    keys = '0;
    repeat (160) tick();

    chk("valid_width", dbl, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
